// File: rtl/fifo_pkg.sv
// Shared FIFO pointer helpers: default geometry, synchroniser depth and
// binary/Gray conversions sized for any pointer up to PTR_MAX_W bits.
package fifo_pkg;

  localparam int FIFO_ADDR_SIZE = 4;
  localparam int SYNC_STAGES    = 2;
  localparam int PTR_MAX_W      = 32;

  typedef logic [PTR_MAX_W-1:0] ptr_word_t;

  function automatic ptr_word_t bin2gray(input ptr_word_t bin);
    return bin ^ (bin >> 1);
  endfunction

  // Zero-extended Gray codes convert correctly because the upper bits stay 0.
  function automatic ptr_word_t gray2bin(input ptr_word_t gray);
    ptr_word_t bin;
    bin[PTR_MAX_W-1] = gray[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/ptr_sync_2ff.sv
// Multi-flop synchroniser for a Gray-coded pointer crossing into clk.
// Shared by the write and read sides of the FIFO.
module ptr_sync_2ff
  import fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_ADDR_SIZE + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [SYNC_STAGES];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= d;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign q = stage[SYNC_STAGES-1];

endmodule

// File: rtl/fifo_wptr_full.sv
// Write-side pointer and full/almost-full logic of an async FIFO.
// Optional sticky overflow flag enabled by macro FIFO_OVERFLOW_FLAG_EN.
module fifo_wptr_full
  import fifo_pkg::*;
#(
  parameter int ADDR_SIZE = FIFO_ADDR_SIZE,
  parameter int AF_THRESH = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 wr_req,
  input  logic [ADDR_SIZE:0]   rptr_gray_async,
  output logic                 wr_en_mem,
  output logic [ADDR_SIZE-1:0] waddr,
  output logic [ADDR_SIZE:0]   wptr_gray,
  output logic                 full,
  output logic                 almost_full,
  output logic [ADDR_SIZE:0]   wr_level,
  output logic                 overflow
);

  localparam int PW = ADDR_SIZE + 1;
  localparam logic [ADDR_SIZE:0] DEPTH = {1'b1, {ADDR_SIZE{1'b0}}};

  logic [ADDR_SIZE:0] rq2;
  logic [ADDR_SIZE:0] rq2_bin;
  logic [ADDR_SIZE:0] wbin;
  logic [ADDR_SIZE:0] wbin_next;
  logic [ADDR_SIZE:0] wgray_next;
  logic [ADDR_SIZE:0] full_match;
  logic [ADDR_SIZE:0] level_next;
  logic [ADDR_SIZE:0] free_next;
  logic               wr_inc;
  logic               full_next;
  logic               almost_full_next;

  ptr_sync_2ff #(.WIDTH(PW)) u_rptr_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (rptr_gray_async),
    .q       (rq2)
  );

  assign rq2_bin = PW'(gray2bin(ptr_word_t'(rq2)));

  assign wr_inc    = wr_req & ~full;
  // Gating with reset_n keeps the memory from writing while the pointer is held in reset.
  assign wr_en_mem = wr_inc & reset_n;
  assign waddr     = wbin[ADDR_SIZE-1:0];
  assign wr_level  = wbin - rq2_bin;

  assign wbin_next  = wbin + {{ADDR_SIZE{1'b0}}, wr_inc};
  assign wgray_next = PW'(bin2gray(ptr_word_t'(wbin_next)));

  // Full when the write pointer has lapped the read pointer exactly once.
  assign full_match = {~rq2[ADDR_SIZE:ADDR_SIZE-1], rq2[ADDR_SIZE-2:0]};
  assign full_next  = (wgray_next == full_match);

  assign level_next       = wbin_next - rq2_bin;
  assign free_next        = DEPTH - level_next;
  assign almost_full_next = (free_next <= PW'(AF_THRESH));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wbin        <= '0;
      wptr_gray   <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
    end else begin
      wbin        <= wbin_next;
      wptr_gray   <= wgray_next;
      full        <= full_next;
      almost_full <= almost_full_next;
    end
  end

`ifdef FIFO_OVERFLOW_FLAG_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= 1'b0;
    end else if (wr_req && full) begin
      overflow <= 1'b1;
    end
  end
`else
  assign overflow = 1'b0;
`endif

endmodule
